// File: rtl/risc8_com_uart.sv
// risc8_com_uart
// Byte-wide UART on the RISC8 COM bus. DATA (at BASE) reads the receive
// holding register and writes into the TX FIFO. STATUS (at BASE+1) reads
// {2'b0, frame_err, tx_busy, rx_overrun, rx_valid, tx_empty, tx_full}.
// Writing STATUS bit 3 clears rx_overrun, and writing bit 5 clears frame_err.
//
// Ports:
//   clk        system clock (single domain)
//   rst        asynchronous, active-low reset
//   com_addr   COM register address
//   com_wr     COM write data
//   com_wr_en  write strobe
//   com_rd_en  read strobe (side effects only)
//   com_rd     combinational read data
//   uart_tx    serial output, idle high
//   uart_rx    serial input, asynchronous to clk
//   irq        equals rx_valid
module risc8_com_uart #(
    parameter logic [7:0] BASE       = 8'hF0,
    parameter int         CLK_DIV    = 16,
    parameter int         FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] com_addr,
    input  logic [7:0] com_wr,
    input  logic       com_wr_en,
    input  logic       com_rd_en,
    output logic [7:0] com_rd,
    output logic       uart_tx,
    input  logic       uart_rx,
    output logic       irq
);

    localparam int             CW        = $clog2(CLK_DIV);
    localparam int             AW        = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0]  DIV_LAST  = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0]  HALF_LAST = CW'(CLK_DIV / 2 - 1);
    localparam logic [7:0]     STAT_ADDR = BASE + 8'd1;

    // ------------------------------------------------------------------
    // Register decode
    // ------------------------------------------------------------------
    logic data_sel, stat_sel;
    logic push, rd_clear, ovr_clr, fe_clr;
    logic tx_full, tx_empty, tx_busy;
    logic rx_valid, rx_overrun, frame_err;
    logic [7:0] rx_data;
    logic tx_pop;

    assign data_sel = (com_addr == BASE);
    assign stat_sel = (com_addr == STAT_ADDR);
    // A push against a full FIFO is dropped even if a pop frees a slot this cycle.
    assign push     = com_wr_en && data_sel && !tx_full;
    assign rd_clear = com_rd_en && data_sel;
    assign ovr_clr  = com_wr_en && stat_sel && com_wr[3];
    assign fe_clr   = com_wr_en && stat_sel && com_wr[5];

    always_comb begin
        com_rd = 8'h00;
        if (data_sel)
            com_rd = rx_data;
        else if (stat_sel)
            com_rd = {2'b00, frame_err, tx_busy, rx_overrun, rx_valid, tx_empty, tx_full};
    end

    assign irq = rx_valid;

    // ------------------------------------------------------------------
    // TX FIFO: pointers carry one extra wrap bit to tell full from empty
    // ------------------------------------------------------------------
    logic [7:0]  fifo_mem [FIFO_DEPTH];
    logic [AW:0] wptr, rptr;
    logic [7:0]  fifo_head;

    assign tx_empty  = (wptr == rptr);
    assign tx_full   = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign fifo_head = fifo_mem[rptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push)
                wptr <= wptr + 1'b1;
            if (tx_pop)
                rptr <= rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[wptr[AW-1:0]] <= com_wr;
    end

    // ------------------------------------------------------------------
    // TX FSM
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {TIDLE, TSTART, TDATA, TSTOP} tx_state_t;
    tx_state_t     tx_state, tx_next;
    logic [CW-1:0] tx_cnt;
    logic [2:0]    tx_bit;
    logic [7:0]    tx_shift;
    logic          tx_tick;

    assign tx_tick = (tx_cnt == DIV_LAST);
    assign tx_busy = (tx_state != TIDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_state <= TIDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
        end else begin
            tx_state <= tx_next;
            tx_cnt   <= (tx_state == TIDLE || tx_tick) ? '0 : tx_cnt + 1'b1;
            if (tx_state != TDATA)
                tx_bit <= '0;
            else if (tx_tick)
                tx_bit <= tx_bit + 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (tx_pop)
            tx_shift <= fifo_head;
        else if (tx_state == TDATA && tx_tick)
            tx_shift <= {1'b0, tx_shift[7:1]};
    end

    always_comb begin
        tx_next = tx_state;
        tx_pop  = 1'b0;
        uart_tx = 1'b1;
        case (tx_state)
            TIDLE: begin
                if (!tx_empty) begin
                    tx_pop  = 1'b1;
                    tx_next = TSTART;
                end
            end
            TSTART: begin
                uart_tx = 1'b0;
                if (tx_tick)
                    tx_next = TDATA;
            end
            TDATA: begin
                uart_tx = tx_shift[0];
                if (tx_tick && tx_bit == 3'd7)
                    tx_next = TSTOP;
            end
            TSTOP: begin
                // Chain straight into the next start bit when more data waits.
                if (tx_tick) begin
                    if (!tx_empty) begin
                        tx_pop  = 1'b1;
                        tx_next = TSTART;
                    end else begin
                        tx_next = TIDLE;
                    end
                end
            end
            default: tx_next = TIDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // RX synchroniser and falling-edge detector
    // ------------------------------------------------------------------
    logic rx_meta, rx_line, rx_prev, rx_fall;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta <= 1'b1;
            rx_line <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= uart_rx;
            rx_line <= rx_meta;
            rx_prev <= rx_line;
        end
    end

    assign rx_fall = rx_prev && !rx_line;

    // ------------------------------------------------------------------
    // RX FSM
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {RIDLE, RSTART, RDATA, RSTOP} rx_state_t;
    rx_state_t     rx_state, rx_next;
    logic [CW-1:0] rx_cnt;
    logic [2:0]    rx_bit;
    logic [7:0]    rx_shift;
    logic          rx_cnt_clr, rx_sample, stop_ok, stop_bad;
    logic          rx_load, ovr_set;

    always_comb begin
        rx_next    = rx_state;
        rx_cnt_clr = 1'b0;
        rx_sample  = 1'b0;
        stop_ok    = 1'b0;
        stop_bad   = 1'b0;
        case (rx_state)
            RIDLE: begin
                rx_cnt_clr = 1'b1;
                if (rx_fall)
                    rx_next = RSTART;
            end
            RSTART: begin
                // Mid start bit: a line already back high was only a glitch.
                if (rx_cnt == HALF_LAST) begin
                    rx_cnt_clr = 1'b1;
                    rx_next    = rx_line ? RIDLE : RDATA;
                end
            end
            RDATA: begin
                if (rx_cnt == DIV_LAST) begin
                    rx_cnt_clr = 1'b1;
                    rx_sample  = 1'b1;
                    if (rx_bit == 3'd7)
                        rx_next = RSTOP;
                end
            end
            RSTOP: begin
                // Leave at the stop-bit midpoint so the next start edge is seen.
                if (rx_cnt == DIV_LAST) begin
                    rx_cnt_clr = 1'b1;
                    rx_next    = RIDLE;
                    stop_ok    = rx_line;
                    stop_bad   = !rx_line;
                end
            end
            default: rx_next = RIDLE;
        endcase
    end

    // A read-clear landing with a new byte lets the byte in without overrun.
    assign rx_load = stop_ok && (!rx_valid || rd_clear);
    assign ovr_set = stop_ok && rx_valid && !rd_clear;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_state   <= RIDLE;
            rx_cnt     <= '0;
            rx_bit     <= '0;
            rx_valid   <= 1'b0;
            rx_overrun <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            rx_state <= rx_next;
            rx_cnt   <= rx_cnt_clr ? '0 : rx_cnt + 1'b1;
            if (rx_state != RDATA)
                rx_bit <= '0;
            else if (rx_sample)
                rx_bit <= rx_bit + 3'd1;

            if (rx_load)
                rx_valid <= 1'b1;
            else if (rd_clear)
                rx_valid <= 1'b0;

            // Set has priority over a same-cycle clear.
            if (ovr_set)
                rx_overrun <= 1'b1;
            else if (ovr_clr)
                rx_overrun <= 1'b0;

            if (stop_bad)
                frame_err <= 1'b1;
            else if (fe_clr)
                frame_err <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rx_sample)
            rx_shift <= {rx_line, rx_shift[7:1]};
        if (rx_load)
            rx_data <= rx_shift;
    end

endmodule

// File: tb/tb_risc8_com_uart.sv
// tb_risc8_com_uart
// Directed bench for risc8_com_uart with default parameters
// (BASE = F0, CLK_DIV = 16, FIFO_DEPTH = 4). Inputs change on the falling
// clock edge and outputs are sampled there as well.
module tb_risc8_com_uart;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] com_addr;
    logic [7:0] com_wr;
    logic       com_wr_en;
    logic       com_rd_en;
    logic [7:0] com_rd;
    logic       uart_tx;
    logic       uart_rx;
    logic       irq;

    int checks = 0;
    int errors = 0;

    risc8_com_uart dut (
        .clk       (clk),
        .rst       (rst),
        .com_addr  (com_addr),
        .com_wr    (com_wr),
        .com_wr_en (com_wr_en),
        .com_rd_en (com_rd_en),
        .com_rd    (com_rd),
        .uart_tx   (uart_tx),
        .uart_rx   (uart_rx),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stopb);
        uart_rx = 1'b0;
        wait_cycles(16);
        for (int i = 0; i < 8; i++) begin
            uart_rx = d[i];
            wait_cycles(16);
        end
        uart_rx = stopb;
        wait_cycles(16);
        uart_rx = 1'b1;
    endtask

    initial begin
        logic [7:0] byte_v;
        logic       bit_v;
        int         f;
        int         b;

        rst       = 1'b0;
        com_addr  = 8'h00;
        com_wr    = 8'h00;
        com_wr_en = 1'b0;
        com_rd_en = 1'b0;
        uart_rx   = 1'b1;

        // Reset state
        wait_cycles(3);
        com_addr = 8'hF1;
        #1;
        check("rst_status", com_rd, 8'h02);
        check("rst_tx", {7'b0, uart_tx}, 8'h01);
        check("rst_irq", {7'b0, irq}, 8'h00);
        check("rst_other_addr", (com_addr == 8'hF1) ? 8'h00 : 8'hFF, 8'h00);
        com_addr = 8'h33;
        #1;
        check("unmapped_rd", com_rd, 8'h00);
        wait_cycles(1);
        rst = 1'b1;
        com_addr = 8'hF1;
        wait_cycles(2);
        check("post_rst_status", com_rd, 8'h02);

        // Single byte A5
        com_addr  = 8'hF0;
        com_wr    = 8'hA5;
        com_wr_en = 1'b1;
        wait_cycles(1);
        com_wr_en = 1'b0;
        com_addr  = 8'hF1;
        #1;
        check("a5_pre_tx", {7'b0, uart_tx}, 8'h01);
        check("a5_queued_status", com_rd, 8'h00);
        wait_cycles(1);
        byte_v = 8'hA5;
        for (int i = 0; i < 10; i++) begin
            if (i == 0)      bit_v = 1'b0;
            else if (i == 9) bit_v = 1'b1;
            else             bit_v = byte_v[i-1];
            #1;
            check("a5_bit_first", {7'b0, uart_tx}, {7'b0, bit_v});
            check("a5_busy_first", {7'b0, com_rd[4]}, 8'h01);
            wait_cycles(15);
            #1;
            check("a5_bit_last", {7'b0, uart_tx}, {7'b0, bit_v});
            check("a5_busy_last", {7'b0, com_rd[4]}, 8'h01);
            wait_cycles(1);
        end
        #1;
        check("a5_done_tx", {7'b0, uart_tx}, 8'h01);
        check("a5_done_status", com_rd, 8'h02);

        // Five back-to-back writes, sixth dropped
        wait_cycles(1);
        com_addr = 8'hF0;
        for (int k = 0; k < 5; k++) begin
            com_wr    = 8'h11 + 8'(k);
            com_wr_en = 1'b1;
            wait_cycles(1);
        end
        com_wr_en = 1'b0;
        com_addr  = 8'hF1;
        #1;
        check("fifo_full_status", com_rd, 8'h11);
        wait_cycles(1);
        com_addr  = 8'hF0;
        com_wr    = 8'h99;
        com_wr_en = 1'b1;
        wait_cycles(1);
        com_wr_en = 1'b0;
        com_addr  = 8'hF1;
        #1;
        check("fifo_full_after_drop", com_rd, 8'h11);
        // Now 5 cycles past the first pop; move to the middle of the first start bit.
        wait_cycles(3);
        for (int j = 0; j < 50; j++) begin
            f = j / 10;
            b = j % 10;
            byte_v = 8'h11 + 8'(f);
            if (b == 0)      bit_v = 1'b0;
            else if (b == 9) bit_v = 1'b1;
            else             bit_v = byte_v[b-1];
            #1;
            check("burst_bit", {7'b0, uart_tx}, {7'b0, bit_v});
            wait_cycles(16);
        end
        #1;
        check("burst_done_tx", {7'b0, uart_tx}, 8'h01);
        check("burst_done_status", com_rd, 8'h02);

        // Receive 3C, then read-clear
        send_frame(8'h3C, 1'b1);
        wait_cycles(4);
        com_addr = 8'hF0;
        #1;
        check("rx3c_data", com_rd, 8'h3C);
        check("rx3c_irq", {7'b0, irq}, 8'h01);
        com_addr = 8'hF1;
        #1;
        check("rx3c_status", com_rd, 8'h06);
        wait_cycles(1);
        com_addr  = 8'hF0;
        com_rd_en = 1'b1;
        wait_cycles(1);
        com_rd_en = 1'b0;
        com_addr  = 8'hF1;
        #1;
        check("rx3c_cleared", com_rd, 8'h02);
        check("rx3c_irq_clr", {7'b0, irq}, 8'h00);

        // Overrun: 01 then 02 with no read
        send_frame(8'h01, 1'b1);
        send_frame(8'h02, 1'b1);
        wait_cycles(4);
        com_addr = 8'hF0;
        #1;
        check("ovr_data_kept", com_rd, 8'h01);
        com_addr = 8'hF1;
        #1;
        check("ovr_status", com_rd, 8'h0E);
        wait_cycles(1);
        com_wr    = 8'h08;
        com_wr_en = 1'b1;
        wait_cycles(1);
        com_wr_en = 1'b0;
        #1;
        check("ovr_cleared", com_rd, 8'h06);
        wait_cycles(1);
        com_addr  = 8'hF0;
        com_rd_en = 1'b1;
        wait_cycles(1);
        com_rd_en = 1'b0;
        com_addr  = 8'hF1;
        #1;
        check("ovr_valid_cleared", com_rd, 8'h02);

        // Framing error
        send_frame(8'h55, 1'b0);
        wait_cycles(4);
        #1;
        check("fe_status", com_rd, 8'h22);
        check("fe_irq", {7'b0, irq}, 8'h00);
        wait_cycles(1);
        com_wr    = 8'h20;
        com_wr_en = 1'b1;
        wait_cycles(1);
        com_wr_en = 1'b0;
        #1;
        check("fe_cleared", com_rd, 8'h02);

        // Short low glitch
        wait_cycles(1);
        uart_rx = 1'b0;
        wait_cycles(3);
        uart_rx = 1'b1;
        wait_cycles(200);
        #1;
        check("glitch_status", com_rd, 8'h02);
        check("glitch_irq", {7'b0, irq}, 8'h00);

        // Reset mid-frame
        wait_cycles(1);
        com_addr  = 8'hF0;
        com_wr    = 8'h00;
        com_wr_en = 1'b1;
        wait_cycles(2);
        com_wr_en = 1'b0;
        com_addr  = 8'hF1;
        wait_cycles(20);
        #1;
        check("midtx_low", {7'b0, uart_tx}, 8'h00);
        check("midtx_busy", {7'b0, com_rd[4]}, 8'h01);
        wait_cycles(1);
        rst = 1'b0;
        #1;
        check("midtx_rst_tx", {7'b0, uart_tx}, 8'h01);
        check("midtx_rst_status", com_rd, 8'h02);
        wait_cycles(2);
        rst = 1'b1;
        wait_cycles(40);
        #1;
        check("midtx_after_tx", {7'b0, uart_tx}, 8'h01);
        check("midtx_after_status", com_rd, 8'h02);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
